// File: rtl/rtrt_pkg.sv
// Shared types for the ray/sphere dispatcher: 9-bit coordinates, vectors,
// sphere table entries and the dispatcher state encoding.
package rtrt_pkg;

  typedef logic [8:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } vec3_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
    coord_t r;
  } sphere_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_NEXT,
    ST_FINISH
  } disp_state_t;

  // A zero radius marks a table entry as disabled.
  function automatic logic sphere_enabled(input sphere_t s);
    return s.r != '0;
  endfunction

endpackage

// File: rtl/ray_sphere_dispatcher_sphere_table.sv
// sphere_table: NUM_SPHERES x sphere_t register file with one write port,
// one combinational read port and asynchronous clear.
module sphere_table
  import rtrt_pkg::*;
#(
  parameter  int unsigned NUM_SPHERES = 8,
  localparam int unsigned IDX_W       = $clog2(NUM_SPHERES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sphere_t          wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output sphere_t          rd_data
);

  sphere_t entries_q [NUM_SPHERES];
  sphere_t entries_d [NUM_SPHERES];

  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPHERES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_data = entries_q[rd_idx];

endmodule

// File: rtl/ray_sphere_dispatcher.sv
// Walks the sphere table in index order, handing each enabled sphere to an
// external intersection unit. Optional watchdog: RTRT_DISPATCH_TIMEOUT_EN.
module ray_sphere_dispatcher
  import rtrt_pkg::*;
#(
  parameter  int unsigned NUM_SPHERES    = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IDX_W          = $clog2(NUM_SPHERES),
  localparam int unsigned HCNT_W         = IDX_W + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  vec3_t             RAY_P0,
  input  vec3_t             RAY_P1,
  input  logic              SPH_WR,
  input  logic [IDX_W-1:0]  SPH_WR_IDX,
  input  sphere_t           SPH_WR_DATA,
  output logic              ISECT_ENABLE,
  output sphere_t           ISECT_SPHERE,
  output vec3_t             ISECT_P0,
  output vec3_t             ISECT_P1,
  input  logic              ISECT_READY,
  input  logic              ISECT_COLLIDE,
  output logic              BUSY,
  output logic              DONE,
  output logic              HIT,
  output logic [IDX_W-1:0]  HIT_IDX,
  output logic [HCNT_W-1:0] HIT_COUNT,
  output logic              TIMEOUT
);

  disp_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
  vec3_t             p0_q, p0_d;
  vec3_t             p1_q, p1_d;
  logic              hit_q, hit_d;
  logic [HCNT_W-1:0] hit_count_q, hit_count_d;
  logic              timeout_q, timeout_d;
  sphere_t           cur_sph;
  logic              last_idx;
  logic              wd_expire;
  logic              tbl_wr;

  // Writes land only in IDLE, so an entry cannot change under a traversal.
  assign tbl_wr = SPH_WR && (state_q == ST_IDLE);

  sphere_table #(.NUM_SPHERES(NUM_SPHERES)) u_table (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (tbl_wr),
    .wr_idx  (SPH_WR_IDX),
    .wr_data (SPH_WR_DATA),
    .rd_idx  (idx_q),
    .rd_data (cur_sph)
  );

  assign last_idx = (idx_q == IDX_W'(NUM_SPHERES - 1));

`ifdef RTRT_DISPATCH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            in_wait;

  assign in_wait = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);
  // Firing on wait cycle TIMEOUT_CYCLES-1 places FINISH TIMEOUT_CYCLES after ISSUE.
  assign wd_expire = in_wait && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 2));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (in_wait) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      hit_idx_q   <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_idx_q   <= hit_idx_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (START) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = sphere_enabled(cur_sph) ? ST_WAIT_LOW : ST_NEXT;
      ST_WAIT_LOW: begin
        if (!ISECT_READY)  state_d = ST_WAIT_HIGH;
        else if (wd_expire) state_d = ST_FINISH;
      end
      ST_WAIT_HIGH: begin
        if (ISECT_READY)    state_d = ST_NEXT;
        else if (wd_expire) state_d = ST_FINISH;
      end
      ST_NEXT:      state_d = last_idx ? ST_FINISH : ST_ISSUE;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    hit_idx_d   = hit_idx_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          p0_d        = RAY_P0;
          p1_d        = RAY_P1;
          idx_d       = '0;
          hit_d       = 1'b0;
          hit_idx_d   = '0;
          hit_count_d = '0;
          timeout_d   = 1'b0;
        end
      end
      ST_WAIT_LOW: begin
        if (ISECT_READY && wd_expire) timeout_d = 1'b1;
      end
      ST_WAIT_HIGH: begin
        if (ISECT_READY) begin
          if (ISECT_COLLIDE) begin
            if (hit_count_q != '1) hit_count_d = hit_count_q + HCNT_W'(1);
            if (!hit_q) begin
              hit_d     = 1'b1;
              hit_idx_d = idx_q;
            end
          end
        end else if (wd_expire) begin
          timeout_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (!last_idx) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ISECT_ENABLE = (state_q == ST_ISSUE) && sphere_enabled(cur_sph);
    ISECT_SPHERE = cur_sph;
    ISECT_P0     = p0_q;
    ISECT_P1     = p1_q;
    BUSY         = (state_q != ST_IDLE);
    DONE         = (state_q == ST_FINISH);
    HIT          = hit_q;
    HIT_IDX      = hit_idx_q;
    HIT_COUNT    = hit_count_q;
    TIMEOUT      = timeout_q;
  end

endmodule

// File: tb/tb_ray_sphere_dispatcher.sv
// Randomized self-checking bench for ray_sphere_dispatcher with a behavioural
// intersection-unit responder and a table/result reference model.
module tb_ray_sphere_dispatcher;
  import rtrt_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 64;

  logic          CLK = 1'b0;
  logic          RESET, START, SPH_WR;
  logic          ISECT_ENABLE, ISECT_READY, ISECT_COLLIDE;
  logic          BUSY, DONE, HIT, TIMEOUT;
  vec3_t         RAY_P0, RAY_P1, ISECT_P0, ISECT_P1;
  logic [IW-1:0] SPH_WR_IDX, HIT_IDX;
  logic [CW-1:0] HIT_COUNT;
  sphere_t       SPH_WR_DATA, ISECT_SPHERE;

  ray_sphere_dispatcher #(.NUM_SPHERES(N), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RAY_P0(RAY_P0), .RAY_P1(RAY_P1),
    .SPH_WR(SPH_WR), .SPH_WR_IDX(SPH_WR_IDX), .SPH_WR_DATA(SPH_WR_DATA),
    .ISECT_ENABLE(ISECT_ENABLE), .ISECT_SPHERE(ISECT_SPHERE),
    .ISECT_P0(ISECT_P0), .ISECT_P1(ISECT_P1),
    .ISECT_READY(ISECT_READY), .ISECT_COLLIDE(ISECT_COLLIDE),
    .BUSY(BUSY), .DONE(DONE), .HIT(HIT), .HIT_IDX(HIT_IDX),
    .HIT_COUNT(HIT_COUNT), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  sphere_t      shadow [N];
  logic [N-1:0] collide_mask;
  bit           hang_en   = 1'b0;
  int           hang_idx  = 0;
  bit           rand_dly  = 1'b0;
  int           exp_q[$];
  vec3_t        ray0, ray1;
  int           req_seen = 0, done_seen = 0, rst_epoch = 0;
  int           cyc = 0, done_cyc = 0, last_req_cyc = 0;
  bit           ex_hit, ex_to;
  int           ex_idx, ex_cnt, ex_req;

  function automatic vec3_t rand_vec();
    logic [26:0] t;
    t = 27'($urandom);
    return vec3_t'(t);
  endfunction

  function automatic sphere_t rand_sph(input bit enabled);
    sphere_t s;
    s.x = 9'($urandom);
    s.y = 9'($urandom);
    s.z = 9'($urandom);
    s.r = enabled ? 9'($urandom_range(511, 1)) : 9'd0;
    return s;
  endfunction

  // Expected outcome: enabled entries are visited in ascending order; a hung
  // request ends the run with TIMEOUT and whatever was accumulated before it.
  task automatic build_expect();
    bit stop;
    exp_q.delete();
    ex_hit = 1'b0; ex_to = 1'b0; ex_idx = 0; ex_cnt = 0; ex_req = 0; stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stop && shadow[i].r != '0) begin
        exp_q.push_back(i);
        ex_req++;
        if (hang_en && i == hang_idx) begin
          ex_to = 1'b1;
          stop  = 1'b1;
        end else if (collide_mask[i]) begin
          if (!ex_hit) begin
            ex_hit = 1'b1;
            ex_idx = i;
          end
          ex_cnt++;
        end
      end
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
  end

  // Intersection unit: READY drops some cycles after a request, rises later
  // with the result for one cycle; COLLIDE is junk-high outside that cycle.
  initial begin : responder
    int      idx, epoch, dl, dh;
    sphere_t s;
    vec3_t   a, b;
    bit      moved;
    ISECT_READY   = 1'b1;
    ISECT_COLLIDE = 1'b0;
    forever begin
      @(negedge CLK);
      ISECT_COLLIDE = 1'b1;
      if (ISECT_ENABLE === 1'b1) begin
        req_seen++;
        last_req_cyc = cyc;
        epoch = rst_epoch;
        idx = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check_eq("req_sphere", 64'(ISECT_SPHERE), 64'(shadow[idx]));
        check_eq("req_p0", 64'(ISECT_P0), 64'(ray0));
        check_eq("req_p1", 64'(ISECT_P1), 64'(ray1));
        s = ISECT_SPHERE; a = ISECT_P0; b = ISECT_P1; moved = 1'b0;
        dl = rand_dly ? int'($urandom_range(3, 1)) : 1;
        dh = rand_dly ? int'($urandom_range(6, 1)) : 4;
        for (int k = 0; k < dl; k++) begin
          @(negedge CLK);
          moved |= (ISECT_SPHERE !== s) || (ISECT_P0 !== a) || (ISECT_P1 !== b);
        end
        ISECT_READY   = 1'b0;
        ISECT_COLLIDE = 1'($urandom);
        if (hang_en && idx == hang_idx) begin
          for (int k = 0; k < 4 * TO && DONE !== 1'b1; k++) @(negedge CLK);
          ISECT_READY = 1'b1;
        end else begin
          for (int k = 0; k < dh; k++) begin
            @(negedge CLK);
            moved |= (ISECT_SPHERE !== s) || (ISECT_P0 !== a) || (ISECT_P1 !== b);
          end
          ISECT_READY   = 1'b1;
          ISECT_COLLIDE = collide_mask[idx];
          if (rst_epoch == epoch) check_eq("operands_stable", 64'(moved), 64'(0));
        end
      end
    end
  end

  task automatic table_write(input int i, input sphere_t s);
    @(negedge CLK);
    SPH_WR = 1'b1; SPH_WR_IDX = IW'(i); SPH_WR_DATA = s;
    shadow[i] = s;
    @(negedge CLK);
    SPH_WR = 1'b0;
  endtask

  task automatic traverse(input string tag, input bit wr_with_start, input int wr_i,
                          input sphere_t wr_s, input bit wr_busy, output int lat);
    int d0;
    if (wr_with_start) shadow[wr_i] = wr_s;
    build_expect();
    ray0 = rand_vec(); ray1 = rand_vec();
    req_seen = 0;
    d0 = done_seen;
    @(negedge CLK);
    check_eq({tag, "_idle_busy"}, 64'(BUSY), 64'(0));
    START = 1'b1; RAY_P0 = ray0; RAY_P1 = ray1;
    if (wr_with_start) begin
      SPH_WR = 1'b1; SPH_WR_IDX = IW'(wr_i); SPH_WR_DATA = wr_s;
    end
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        START = 1'b0; SPH_WR = 1'b0;
        RAY_P0 = rand_vec(); RAY_P1 = rand_vec();
        check_eq({tag, "_busy"}, 64'(BUSY), 64'(1));
      end
      if (lat == 2) START = 1'b1;
      if (lat == 3) begin
        START = 1'b0;
        if (wr_busy) begin
          SPH_WR = 1'b1; SPH_WR_IDX = IW'(wr_i); SPH_WR_DATA = wr_s;
        end
      end
      if (lat == 4) SPH_WR = 1'b0;
    end while (DONE !== 1'b1 && lat < 3000);
    check_eq({tag, "_done"}, 64'(DONE), 64'(1));
    check_eq({tag, "_hit"}, 64'(HIT), 64'(ex_hit));
    check_eq({tag, "_hit_idx"}, 64'(HIT_IDX), 64'(ex_idx));
    check_eq({tag, "_hit_count"}, 64'(HIT_COUNT), 64'(ex_cnt));
    check_eq({tag, "_timeout"}, 64'(TIMEOUT), 64'(ex_to));
    check_eq({tag, "_requests"}, 64'(req_seen), 64'(ex_req));
    @(negedge CLK);
    check_eq({tag, "_done_pulse"}, 64'(DONE), 64'(0));
    check_eq({tag, "_idle"}, 64'(BUSY), 64'(0));
    check_eq({tag, "_hold"}, 64'({HIT, HIT_IDX, HIT_COUNT}), 64'({ex_hit, IW'(ex_idx), CW'(ex_cnt)}));
    check_eq({tag, "_done_count"}, 64'(done_seen - d0), 64'(1));
  endtask

  initial begin : main
    int      lat, d0, k, nw;
    sphere_t s;
    RESET = 1'b1; START = 1'b0; SPH_WR = 1'b0; SPH_WR_IDX = '0; SPH_WR_DATA = '0;
    RAY_P0 = '0; RAY_P1 = '0;
    for (int i = 0; i < N; i++) shadow[i] = '0;
    collide_mask = '1;
    repeat (3) @(negedge CLK);
    check_eq("rst_outputs", 64'({ISECT_ENABLE, BUSY, DONE, HIT, TIMEOUT}), 64'(0));
    check_eq("rst_result", 64'({HIT_IDX, HIT_COUNT}), 64'(0));
    check_eq("rst_operands", 64'({ISECT_SPHERE, ISECT_P0}), 64'(0));
    RESET = 1'b0;

    // Every entry disabled after reset: no requests, 2N+1 cycle latency.
    traverse("all_off", 1'b0, 0, '0, 1'b0, lat);
    check_eq("all_off_latency", 64'(lat), 64'(2 * N + 1));

    // Entries 2 and 5 enabled, both collide, fixed 1/4 cycle handshake.
    table_write(2, rand_sph(1'b1));
    table_write(5, rand_sph(1'b1));
    collide_mask = 8'b0010_0100;
    traverse("two_hits", 1'b0, 0, '0, 1'b0, lat);

    // A write to entry 3 while busy is dropped; with START it is used.
    s = rand_sph(1'b1);
    collide_mask = 8'b0010_1000;
    traverse("busy_write", 1'b0, 3, s, 1'b1, lat);
    traverse("start_write", 1'b1, 3, s, 1'b0, lat);

    // Reset during WAIT_HIGH aborts with no DONE; the next run is honoured.
    build_expect();
    ray0 = rand_vec(); ray1 = rand_vec();
    @(negedge CLK);
    START = 1'b1; RAY_P0 = ray0; RAY_P1 = ray1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (ISECT_READY !== 1'b0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check_eq("rst_reach_wait", 64'(ISECT_READY), 64'(0));
    @(negedge CLK);
    check_eq("rst_pre_busy", 64'(BUSY), 64'(1));
    d0 = done_seen;
    #2;
    RESET = 1'b1;
    rst_epoch++;
    #1;
    check_eq("rst_async_outputs", 64'({ISECT_ENABLE, BUSY, DONE, HIT, TIMEOUT}), 64'(0));
    check_eq("rst_async_result", 64'({HIT_IDX, HIT_COUNT}), 64'(0));
    check_eq("rst_async_operands", 64'({ISECT_SPHERE, ISECT_P0, ISECT_P1}), 64'(0));
    for (int i = 0; i < N; i++) shadow[i] = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check_eq("rst_no_done", 64'(done_seen - d0), 64'(0));
    traverse("post_rst", 1'b0, 0, '0, 1'b0, lat);
    check_eq("post_rst_latency", 64'(lat), 64'(2 * N + 1));

    // Randomized tables, masks, handshake delays and write timing.
    rand_dly = 1'b1;
    for (int it = 0; it < 20; it++) begin
      nw = int'($urandom_range(4, 0));
      for (int w = 0; w < nw; w++) table_write(int'($urandom_range(N - 1, 0)), rand_sph(1'($urandom)));
      collide_mask = N'($urandom);
      traverse("rand", ($urandom_range(3, 0) == 0), int'($urandom_range(N - 1, 0)),
               rand_sph(1'($urandom)), ($urandom_range(3, 0) == 0), lat);
    end

`ifdef RTRT_DISPATCH_TIMEOUT_EN
    // Entry 4 never completes: watchdog ends the run TO cycles after its ISSUE.
    table_write(0, rand_sph(1'b1));
    table_write(4, rand_sph(1'b1));
    collide_mask = 8'b0000_0001;
    hang_en = 1'b1; hang_idx = 4; rand_dly = 1'b0;
    traverse("watchdog", 1'b0, 0, '0, 1'b0, lat);
    check_eq("watchdog_latency", 64'(done_cyc - last_req_cyc), 64'(TO));
    hang_en = 1'b0;
`endif

    repeat (12) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
